reg_write_ctrl: RTL and testbench
=================================

REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_REGS, 8, number of general registers (power of 2, >= NUM_BYTE_REGS).
- NUM_BYTE_REGS, 4, registers with separately addressable high/low halves.
- DATA_W, 16, register width (even); H = DATA_W/2 is the half width.
- SEL_W = $clog2(NUM_REGS), derived local constant.

REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is synchronous and active-low.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept.
- req_op  in  2  00 WRITE, 01 XCHG, 10/11 reserved.
- req_dst  in  SEL_W  destination register index.
- req_src  in  SEL_W  source register index (XCHG only).
- req_size  in  1  1 = full width, 0 = half width.
- req_high  in  1  half select: 1 = high, 0 = low (half width only).
- req_data  in  DATA_W  write data (WRITE only; half writes use bits H-1:0).
- rd_sel  out  SEL_W  register-file read index.
- rd_data  in  DATA_W  combinational read data for rd_sel.
- wr_en  out  NUM_REGS  one-hot register write strobe.
- wr_half  out  2  half mask: 11 full, 10 high, 01 low.
- wr_data  out  DATA_W  lane-aligned write data.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-request pulse.

Function
REQ-003 A request is accepted on a rising edge with req_valid && req_ready; req_ready = 1 only in IDLE; request fields are captured at acceptance and the inputs are then ignored until the next acceptance.
REQ-004 FSM states are IDLE, RD_A, RD_B, WR_A, WR_B and ERR.
REQ-005 Illegal request: a reserved op, or req_size = 0 with any used index >= NUM_BYTE_REGS. The transition is IDLE -> ERR; in ERR, err = 1 and done = 1 for one cycle, no wr_en is asserted, then the FSM returns to IDLE.
REQ-006 WRITE: IDLE -> WR_A -> IDLE. In WR_A, wr_en targets the dst bit only, and wr_en is asserted exactly 1 cycle after acceptance.
REQ-007 XCHG with dst != src: IDLE -> RD_A -> RD_B -> WR_A -> WR_B -> IDLE, as follows.
- RD_A: rd_sel = dst; the state latches tmp_a.
- RD_B: rd_sel = src; the state latches tmp_b.
- WR_A: writes dst <= tmp_b.
- WR_B: writes src <= tmp_a.
REQ-008 XCHG with dst == src: IDLE -> WR_B, where WR_B pulses done with wr_en = 0, then IDLE. There is no register write.
REQ-009 done = 1 in the final WR state (WR_A for WRITE, WR_B for XCHG) and in ERR; it is 0 otherwise.
REQ-010 For half-width operations, tmp_a and tmp_b capture the selected half of rd_data (high: DATA_W-1:H, low: H-1:0), zero-extended.
REQ-011 Lane alignment.
- Full: wr_data = value and wr_half = 11.
- High: wr_data = {value[H-1:0], H'b0} and wr_half = 10.
- Low: wr_data = {H'b0, value[H-1:0]} and wr_half = 01.
REQ-012 Outside write states: wr_en = 0, wr_half = 00, wr_data = 0. rd_sel holds 0 outside the RD states.
REQ-013 All outputs except req_ready shall be registered; req_ready is decoded from the state register.
REQ-014 Back-to-back operation: a new request may be accepted in the cycle the FSM re-enters IDLE, giving a sustained throughput of 1 WRITE per 2 cycles.

Reset
REQ-015 rst_n = 0 at a clock edge puts the FSM in IDLE, clears tmp_a, tmp_b and the captured fields, and sets wr_en, wr_half, wr_data, rd_sel, done and err to 0. req_ready = 1 from the first edge after reset is released.
REQ-016 A reset mid-operation, including in WR_A or WR_B, shall abort the operation with no further write strobe. A partially completed XCHG is not rolled back.

Structure
REQ-017 The shared package/include reg_ctrl_pkg shall hold the op codes, the state encoding, the wr_half constants (FULL, HIGH, LOW, NONE) and the default parameter values.
REQ-018 A sub-module reg_index_decoder shall be instantiated twice (dst and src). It is combinational, maps (index, size, high) to the one-hot enable, the half mask and a legal flag, and is parameterised by NUM_REGS and NUM_BYTE_REGS.

Verification
REQ-019 Directed scenarios the bench shall cover:
- WRITE dst = 2, size = 1, data = 16'hBEEF -> 1 cycle later: wr_en = 8'b00000100, wr_half = 11, wr_data = BEEF, done = 1.
- WRITE dst = 1, size = 0, high = 1, data = 16'h00A5 -> wr_en = 8'b00000010, wr_half = 10, wr_data = 16'hA500.
- XCHG dst = 0, src = 3, full width, with regs R0 = 1111 and R3 = 2222 -> writes R0 <= 2222 at +3, then R3 <= 1111 at +4, done at +4.
- Illegal requests: WRITE dst = 5 with size = 0, and op = 11 -> err and done pulse 1 cycle later, wr_en stays 0.
- XCHG dst = src = 4 -> done at +1, no wr_en. A separate case: rst_n low during RD_B -> no wr_en, IDLE and req_ready = 1 on the following cycle.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register write controller: op codes, FSM
// state encoding, write half-mask constants and default parameter values.
package reg_ctrl_pkg;

  localparam int DEF_NUM_REGS      = 8;
  localparam int DEF_NUM_BYTE_REGS = 4;
  localparam int DEF_DATA_W        = 16;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_XCHG  = 2'b01,
    OP_RSV2  = 2'b10,
    OP_RSV3  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    ERR  = 3'd5
  } state_e;

  localparam logic [1:0] FULL = 2'b11;
  localparam logic [1:0] HIGH = 2'b10;
  localparam logic [1:0] LOW  = 2'b01;
  localparam logic [1:0] NONE = 2'b00;

endpackage

// File: rtl/reg_index_decoder.sv
// Maps a register index plus access size/half to a one-hot write enable,
// the lane half mask and a legality flag (halves exist only on the low
// NUM_BYTE_REGS registers).
module reg_index_decoder
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int NUM_BYTE_REGS = DEF_NUM_BYTE_REGS,
  localparam int SEL_W        = $clog2(NUM_REGS)
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic                size,
  input  logic                high,
  output logic [NUM_REGS-1:0] en,
  output logic [1:0]          half,
  output logic                legal
);

  // Decode index, half mask and legality
  always_comb begin
    en      = '0;
    en[idx] = 1'b1;
    half    = size ? FULL : (high ? HIGH : LOW);
    legal   = size || (int'(idx) < NUM_BYTE_REGS);
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Register write controller: performs WRITE and XCHG requests against an
// external register file through a read index and one-hot write strobes.
//
// state | meaning
// IDLE  | ready for a request
// RD_A  | rd_sel = dst, capture tmp_a
// RD_B  | rd_sel = src, capture tmp_b (aligned straight into wr_data)
// WR_A  | write dst (WRITE data or tmp_b)
// WR_B  | write src <= tmp_a, or no-op completion when dst == src
// ERR   | illegal request, err/done pulse
module reg_write_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int NUM_BYTE_REGS = DEF_NUM_BYTE_REGS,
  parameter int DATA_W        = DEF_DATA_W,
  localparam int SEL_W        = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SEL_W-1:0]    req_dst,
  input  logic [SEL_W-1:0]    req_src,
  input  logic                req_size,
  input  logic                req_high,
  input  logic [DATA_W-1:0]   req_data,
  output logic [SEL_W-1:0]    rd_sel,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [1:0]          wr_half,
  output logic [DATA_W-1:0]   wr_data,
  output logic                done,
  output logic                err
);

  localparam int H = DATA_W / 2;

  state_e              state;
  op_e                 op_q;
  logic                size_q;
  logic                high_q;
  logic [SEL_W-1:0]    src_q;
  logic [NUM_REGS-1:0] dst_en_q;
  logic [NUM_REGS-1:0] src_en_q;
  logic [1:0]          dst_half_q;
  logic [1:0]          src_half_q;
  logic [DATA_W-1:0]   tmp_a;

  logic [NUM_REGS-1:0] dst_en;
  logic [NUM_REGS-1:0] src_en;
  logic [1:0]          dst_half;
  logic [1:0]          src_half;
  logic                dst_legal;
  logic                src_legal;
  logic                req_legal;
  logic [DATA_W-1:0]   rd_pick;

  // Selected half of a read value, zero-extended
  function automatic logic [DATA_W-1:0] pick_half(input logic [DATA_W-1:0] v,
                                                   input logic full, input logic hi);
    if (full)    return v;
    else if (hi) return {{H{1'b0}}, v[DATA_W-1:H]};
    else         return {{H{1'b0}}, v[H-1:0]};
  endfunction

  // Place a value in the lane(s) it will be written to
  function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] v,
                                               input logic full, input logic hi);
    if (full)    return v;
    else if (hi) return {v[H-1:0], {H{1'b0}}};
    else         return {{H{1'b0}}, v[H-1:0]};
  endfunction

  reg_index_decoder #(.NUM_REGS(NUM_REGS), .NUM_BYTE_REGS(NUM_BYTE_REGS)) u_dst_dec (
    .idx(req_dst), .size(req_size), .high(req_high),
    .en(dst_en), .half(dst_half), .legal(dst_legal)
  );

  reg_index_decoder #(.NUM_REGS(NUM_REGS), .NUM_BYTE_REGS(NUM_BYTE_REGS)) u_src_dec (
    .idx(req_src), .size(req_size), .high(req_high),
    .en(src_en), .half(src_half), .legal(src_legal)
  );

  // Source index only matters for XCHG
  assign req_legal = (req_op == OP_WRITE && dst_legal) ||
                     (req_op == OP_XCHG  && dst_legal && src_legal);
  assign req_ready = (state == IDLE);
  assign rd_pick   = pick_half(rd_data, size_q, high_q);

  // Sequencing FSM with registered outputs, computed from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_WRITE;
      size_q     <= 1'b0;
      high_q     <= 1'b0;
      src_q      <= '0;
      dst_en_q   <= '0;
      src_en_q   <= '0;
      dst_half_q <= NONE;
      src_half_q <= NONE;
      tmp_a      <= '0;
      rd_sel     <= '0;
      wr_en      <= '0;
      wr_half    <= NONE;
      wr_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_sel  <= '0;
      wr_en   <= '0;
      wr_half <= NONE;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= op_e'(req_op);
            size_q     <= req_size;
            high_q     <= req_high;
            src_q      <= req_src;
            dst_en_q   <= dst_en;
            src_en_q   <= src_en;
            dst_half_q <= dst_half;
            src_half_q <= src_half;
            if (!req_legal) begin
              state <= ERR;
              err   <= 1'b1;
              done  <= 1'b1;
            end else if (req_op == OP_WRITE) begin
              state   <= WR_A;
              wr_en   <= dst_en;
              wr_half <= dst_half;
              wr_data <= align(req_data, req_size, req_high);
              done    <= 1'b1;
            end else if (req_dst == req_src) begin
              state <= WR_B;
              done  <= 1'b1;
            end else begin
              state  <= RD_A;
              rd_sel <= req_dst;
            end
          end
        end
        RD_A: begin
          tmp_a  <= rd_pick;
          rd_sel <= src_q;
          state  <= RD_B;
        end
        RD_B: begin
          state   <= WR_A;
          wr_en   <= dst_en_q;
          wr_half <= dst_half_q;
          wr_data <= align(rd_pick, size_q, high_q);
        end
        WR_A: begin
          if (op_q == OP_XCHG) begin
            state   <= WR_B;
            wr_en   <= src_en_q;
            wr_half <= src_half_q;
            wr_data <= align(tmp_a, size_q, high_q);
            done    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed bench for reg_write_ctrl with a small register-file model that
// commits wr_en/wr_half/wr_data on each rising edge.
module tb_reg_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_dst;
  logic [2:0]  req_src;
  logic        req_size;
  logic        req_high;
  logic [15:0] req_data;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
  logic [7:0]  wr_en;
  logic [1:0]  wr_half;
  logic [15:0] wr_data;
  logic        done;
  logic        err;

  logic [15:0] regs [8] = '{default: 16'h0000};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_write_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_dst(req_dst), .req_src(req_src),
    .req_size(req_size), .req_high(req_high), .req_data(req_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_en(wr_en), .wr_half(wr_half), .wr_data(wr_data),
    .done(done), .err(err)
  );

  assign rd_data = regs[rd_sel];

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_en[i])
        regs[i] <= (regs[i] & ~{{8{wr_half[1]}}, {8{wr_half[0]}}}) |
                   (wr_data &  {{8{wr_half[1]}}, {8{wr_half[0]}}});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic size, input logic high, input logic [15:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_dst   = dst;
    req_src   = src;
    req_size  = size;
    req_high  = high;
    req_data  = data;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_dst = 3'd0; req_src = 3'd0;
    req_size = 1'b0; req_high = 1'b0; req_data = 16'h0000;
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_half", wr_half, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", req_ready, 1);

    // Full WRITE R2 = BEEF, then back-to-back half writes
    set_req(2'b00, 3'd2, 3'd0, 1'b1, 1'b0, 16'hBEEF);
    tick();
    chk("w1_wr_en", wr_en, 8'b0000_0100);
    chk("w1_wr_half", wr_half, 2'b11);
    chk("w1_wr_data", wr_data, 16'hBEEF);
    chk("w1_done", done, 1);
    chk("w1_ready", req_ready, 0);
    set_req(2'b00, 3'd1, 3'd0, 1'b0, 1'b1, 16'h00A5);
    tick();
    chk("b2b_idle_ready", req_ready, 1);
    chk("b2b_idle_wr_en", wr_en, 0);
    chk("b2b_idle_done", done, 0);
    tick();
    chk("w2_wr_en", wr_en, 8'b0000_0010);
    chk("w2_wr_half", wr_half, 2'b10);
    chk("w2_wr_data", wr_data, 16'hA500);
    chk("w2_done", done, 1);
    set_req(2'b00, 3'd3, 3'd0, 1'b0, 1'b0, 16'h12C3);
    tick(); tick();
    chk("w3_wr_en", wr_en, 8'b0000_1000);
    chk("w3_wr_half", wr_half, 2'b01);
    chk("w3_wr_data", wr_data, 16'h00C3);
    set_req(2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 16'h1111);
    tick(); tick();
    chk("w4_wr_en", wr_en, 8'b0000_0001);
    set_req(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 16'h2222);
    tick(); tick();
    chk("w5_wr_data", wr_data, 16'h2222);
    req_valid = 1'b0;
    tick();
    chk("reg1_half_high", regs[1], 16'hA500);
    chk("reg2_full", regs[2], 16'hBEEF);
    chk("reg0_pre", regs[0], 16'h1111);
    chk("reg3_pre", regs[3], 16'h2222);

    // Full XCHG R0 <-> R3
    set_req(2'b01, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("x_rda_ready", req_ready, 0);
    chk("x_rda_wr_en", wr_en, 0);
    tick();
    chk("x_rdb_rd_sel", rd_sel, 3);
    chk("x_rdb_done", done, 0);
    tick();
    chk("x_wra_wr_en", wr_en, 8'b0000_0001);
    chk("x_wra_wr_data", wr_data, 16'h2222);
    chk("x_wra_wr_half", wr_half, 2'b11);
    chk("x_wra_done", done, 0);
    chk("x_wra_rd_sel", rd_sel, 0);
    tick();
    chk("x_wrb_wr_en", wr_en, 8'b0000_1000);
    chk("x_wrb_wr_data", wr_data, 16'h1111);
    chk("x_wrb_done", done, 1);
    tick();
    chk("x_end_ready", req_ready, 1);
    chk("x_end_done", done, 0);
    chk("x_reg0", regs[0], 16'h2222);
    chk("x_reg3", regs[3], 16'h1111);

    // Low-half XCHG R0 <-> R3: 0x22 and 0x11 swap
    set_req(2'b01, 3'd0, 3'd3, 1'b0, 1'b0, 16'h0000);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("xl_wra_wr_en", wr_en, 8'b0000_0001);
    chk("xl_wra_wr_half", wr_half, 2'b01);
    chk("xl_wra_wr_data", wr_data, 16'h0011);
    tick();
    chk("xl_wrb_wr_en", wr_en, 8'b0000_1000);
    chk("xl_wrb_wr_data", wr_data, 16'h0022);
    tick();
    chk("xl_reg0", regs[0], 16'h2211);
    chk("xl_reg3", regs[3], 16'h1122);

    // Illegal: half WRITE to R5
    set_req(2'b00, 3'd5, 3'd0, 1'b0, 1'b0, 16'h5555);
    tick();
    req_valid = 1'b0;
    chk("il1_err", err, 1);
    chk("il1_done", done, 1);
    chk("il1_wr_en", wr_en, 0);
    tick();
    chk("il1_err_clr", err, 0);
    chk("il1_ready", req_ready, 1);

    // Illegal: reserved op 11
    set_req(2'b11, 3'd0, 3'd1, 1'b1, 1'b0, 16'h7777);
    tick();
    req_valid = 1'b0;
    chk("il2_err", err, 1);
    chk("il2_done", done, 1);
    chk("il2_wr_en", wr_en, 0);
    tick();
    chk("il2_err_clr", err, 0);

    // Illegal: half XCHG with source R6
    set_req(2'b01, 3'd0, 3'd6, 1'b0, 1'b0, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("il3_err", err, 1);
    chk("il3_rd_sel", rd_sel, 0);
    tick();

    // XCHG with dst == src: completion only
    set_req(2'b01, 3'd4, 3'd4, 1'b1, 1'b0, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("xs_done", done, 1);
    chk("xs_wr_en", wr_en, 0);
    chk("xs_err", err, 0);
    tick();
    chk("xs_end_done", done, 0);
    chk("xs_end_ready", req_ready, 1);

    // Reset during RD_B aborts the exchange
    set_req(2'b01, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0000);
    tick();
    req_valid = 1'b0;
    tick();
    chk("ra_rdb_rd_sel", rd_sel, 3);
    rst_n = 1'b0;
    tick();
    chk("ra_wr_en", wr_en, 0);
    chk("ra_ready", req_ready, 1);
    chk("ra_rd_sel", rd_sel, 0);
    rst_n = 1'b1;
    tick();
    chk("ra_post_wr_en", wr_en, 0);
    chk("ra_post_done", done, 0);
    tick();
    chk("ra_reg0", regs[0], 16'h2211);
    chk("ra_reg3", regs[3], 16'h1122);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
